// File: rtl/speccfa_multi_match.sv
// Multi-channel speculative-path matcher: tracks each CF-Log entry against N_CH
// preloaded blocks in parallel and reports the longest completed block.
module speccfa_multi_match #(
  parameter int ADDR_W  = 16,
  parameter int N_CH    = 4,
  parameter int MAX_LEN = 16,
  parameter int ID_W    = 8,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int IDX_W  = $clog2(MAX_LEN),
  localparam int LEN_W  = IDX_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cflow_hw_wen,
  input  logic [ADDR_W-1:0] cflow_src,
  input  logic [ADDR_W-1:0] cflow_dest,
  input  logic [ADDR_W-1:0] cflow_log_ptr,
  input  logic              cfg_pair_wen,
  input  logic              cfg_len_wen,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dest,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ID_W-1:0]   cfg_id,
  output logic              hit,
  output logic [ID_W-1:0]   hit_id,
  output logic [ADDR_W-1:0] hit_base,
  output logic [LEN_W-1:0]  hit_len,
  output logic              spec_active,
  output logic [15:0]       hit_count
);

  logic [N_CH-1:0]   done_vec;
  logic [N_CH-1:0]   track_after;
  logic [LEN_W-1:0]  cand_len  [N_CH];
  logic [ID_W-1:0]   cand_id   [N_CH];
  logic [ADDR_W-1:0] cand_base [N_CH];

  logic              any_done;
  logic [LEN_W-1:0]  win_len;
  logic [ID_W-1:0]   win_id;
  logic [ADDR_W-1:0] win_base;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [ADDR_W-1:0] src_ram  [MAX_LEN];
      logic [ADDR_W-1:0] dest_ram [MAX_LEN];
      logic [LEN_W-1:0]  len_reg;
      logic [ID_W-1:0]   id_reg;
      logic [ADDR_W-1:0] base_reg;
      logic [IDX_W-1:0]  idx_reg;
      logic              track_reg;

      logic              sel;
      logic              armed;
      logic              match_first;
      logic              match_cur;
      logic [LEN_W-1:0]  idx_inc;
      logic              track_next;
      logic [IDX_W-1:0]  idx_next;
      logic [ADDR_W-1:0] base_next;
      logic              done;

      // A config write to this channel removes it from the current event.
      assign sel         = (cfg_pair_wen || cfg_len_wen) && (cfg_ch == CH_W'(gi));
      assign armed       = (len_reg != '0) && (len_reg <= LEN_W'(MAX_LEN));
      assign match_first = (cflow_src == src_ram[0]) && (cflow_dest == dest_ram[0]);
      assign match_cur   = (cflow_src == src_ram[idx_reg]) && (cflow_dest == dest_ram[idx_reg]);
      assign idx_inc     = {1'b0, idx_reg} + LEN_W'(1);

      always_comb begin
        track_next = track_reg;
        idx_next   = idx_reg;
        base_next  = base_reg;
        done       = 1'b0;
        if (cflow_hw_wen && armed && !sel) begin
          if (track_reg && match_cur) begin
            if (idx_inc == len_reg) done = 1'b1;
            else idx_next = idx_inc[IDX_W-1:0];
          end else if (match_first) begin
            // Fresh start, or restart on the entry that broke the previous attempt.
            base_next = cflow_log_ptr;
            if (len_reg == LEN_W'(1)) begin
              done       = 1'b1;
              track_next = 1'b0;
              idx_next   = '0;
            end else begin
              track_next = 1'b1;
              idx_next   = IDX_W'(1);
            end
          end else begin
            track_next = 1'b0;
            idx_next   = '0;
          end
        end
        if (sel) begin
          track_next = 1'b0;
          idx_next   = '0;
        end
      end

      assign done_vec[gi]    = done;
      assign track_after[gi] = track_next && !any_done;
      assign cand_len[gi]    = len_reg;
      assign cand_id[gi]     = id_reg;
      assign cand_base[gi]   = base_next;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < MAX_LEN; i++) begin
            src_ram[i]  <= '0;
            dest_ram[i] <= '0;
          end
          len_reg   <= '0;
          id_reg    <= '0;
          base_reg  <= '0;
          idx_reg   <= '0;
          track_reg <= 1'b0;
        end else begin
          if (sel && cfg_pair_wen) begin
            src_ram[cfg_idx]  <= cfg_src;
            dest_ram[cfg_idx] <= cfg_dest;
          end
          if (sel && cfg_len_wen) begin
            len_reg <= cfg_len;
            id_reg  <= cfg_id;
          end
          // Any completion rewinds the log, so every channel starts over.
          track_reg <= track_after[gi];
          idx_reg   <= any_done ? '0 : idx_next;
          base_reg  <= base_next;
        end
      end
    end
  endgenerate

  // Longest block wins; strict compare keeps the lowest channel on ties.
  always_comb begin
    any_done = 1'b0;
    win_len  = '0;
    win_id   = '0;
    win_base = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (done_vec[c] && (!any_done || (cand_len[c] > win_len))) begin
        any_done = 1'b1;
        win_len  = cand_len[c];
        win_id   = cand_id[c];
        win_base = cand_base[c];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit         <= 1'b0;
      hit_id      <= '0;
      hit_base    <= '0;
      hit_len     <= '0;
      spec_active <= 1'b0;
      hit_count   <= '0;
    end else begin
      hit         <= any_done;
      spec_active <= |track_after;
      if (any_done) begin
        hit_id   <= win_id;
        hit_base <= win_base;
        hit_len  <= win_len;
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end
    end
  end

endmodule
